// File: rtl/fir_stream_driver_if.sv
// Stream-side signals of the FIR driver: upstream sample handshake and FIR sample/coefficient port.
// The master modport is the driver itself; slave is the environment (sample source and FIR).
interface fir_stream_driver_if;
    logic [5:0] smp_data;
    logic       smp_valid;
    logic       smp_ready;
    logic [5:0] fir_tdata;
    logic       fir_tvalid;
    logic       fir_set_coeffs;
    logic       fir_tready;

    modport master (
        input  smp_data,
        input  smp_valid,
        input  fir_tready,
        output smp_ready,
        output fir_tdata,
        output fir_tvalid,
        output fir_set_coeffs
    );

    modport slave (
        output smp_data,
        output smp_valid,
        output fir_tready,
        input  smp_ready,
        input  fir_tdata,
        input  fir_tvalid,
        input  fir_set_coeffs
    );
endinterface

// File: rtl/fir_stream_driver.sv
// Transmit-side driver for the 8-tap FIR: serialises a captured coefficient set into a
// 3-word load sequence and streams buffered 6-bit samples with a valid/ready handshake.
module fir_stream_driver #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [15:0]                        cfg_taps,
    input  logic                               cfg_load,
    output logic                               cfg_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    fir_stream_driver_if.master                bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_STREAM,
        ST_LOAD0,
        ST_LOAD1,
        ST_LOAD2,
        ST_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     taps_q, taps_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            set_q, set_d;
    logic [5:0]      word_q, word_d;
    logic            busy_q, busy_d;

    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic            full_q, full_d;
    logic [5:0]      mem_q [FIFO_DEPTH];

    logic            stream_valid;
    logic            push;
    logic            pop;

    // Load word and strobe are produced one state ahead so they leave straight from flops.
    always_comb begin
        state_d = state_q;
        taps_d  = taps_q;
        gap_d   = gap_q;
        set_d   = 1'b0;
        word_d  = '0;
        case (state_q)
            ST_STREAM: begin
                if (cfg_load) begin
                    state_d = ST_LOAD0;
                    taps_d  = cfg_taps;
                    set_d   = 1'b1;
                    word_d  = {cfg_taps[13:12], cfg_taps[15:14], 2'b00};
                end
            end
            ST_LOAD0: begin
                state_d = ST_LOAD1;
                set_d   = 1'b1;
                word_d  = {taps_q[7:6], taps_q[9:8], taps_q[11:10]};
            end
            ST_LOAD1: begin
                state_d = ST_LOAD2;
                set_d   = 1'b1;
                word_d  = {taps_q[1:0], taps_q[3:2], taps_q[5:4]};
            end
            ST_LOAD2: begin
                if (GAP_CYCLES == 0) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = GW'(GAP_CYCLES - 1);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_STREAM;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = ST_STREAM;
        endcase
        busy_d = (state_d != ST_STREAM);
    end

    assign stream_valid = (state_q == ST_STREAM) && (cnt_q != '0);
    // A load request wins over the handshake in the same cycle, so the head stays queued.
    assign pop  = stream_valid && bus.fir_tready && !cfg_load;
    assign push = bus.smp_valid && !full_q;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        if (push) begin
            wr_d = wr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d = (cnt_d == LW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STREAM;
            taps_q  <= '0;
            gap_q   <= '0;
            set_q   <= 1'b0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            taps_q  <= taps_d;
            gap_q   <= gap_d;
            set_q   <= set_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= bus.smp_data;
        end
    end

    assign bus.fir_set_coeffs = set_q;
    assign bus.fir_tvalid     = stream_valid;
    assign bus.fir_tdata      = set_q ? word_q : (stream_valid ? mem_q[rd_q] : '0);
    assign bus.smp_ready      = !full_q;
    assign cfg_busy           = busy_q;
    assign fifo_level         = cnt_q;

endmodule
